// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side handshake between the DEC stage and the hazard/stall controller.
// The master drives the instruction description; the slave returns buffer controls.
interface hazard_stall_ctrl_if #(
    parameter int REG_INDEX_BIT_WIDTH = 4
);
    logic                           dec_valid;
    logic [REG_INDEX_BIT_WIDTH-1:0] dec_src1;
    logic [REG_INDEX_BIT_WIDTH-1:0] dec_src2;
    logic                           dec_use_src1;
    logic                           dec_use_src2;
    logic [REG_INDEX_BIT_WIDTH-1:0] dec_dst;
    logic                           dec_reg_file_wrt_en;
    logic                           exe_br_taken;
    logic                           fe_dec_en;
    logic                           fe_dec_flush;
    logic                           dec_exe_bubble;

    modport master (
        output dec_valid, dec_src1, dec_src2, dec_use_src1, dec_use_src2,
               dec_dst, dec_reg_file_wrt_en, exe_br_taken,
        input  fe_dec_en, fe_dec_flush, dec_exe_bubble
    );

    modport slave (
        input  dec_valid, dec_src1, dec_src2, dec_use_src1, dec_use_src2,
               dec_dst, dec_reg_file_wrt_en, exe_br_taken,
        output fe_dec_en, fe_dec_flush, dec_exe_bubble
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the FE/DEC and DEC/EXE buffers, tracking in-flight
// destination registers in EXE, MEM and WB to detect read-after-write hazards.
module hazard_stall_ctrl #(
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int CNT_WIDTH           = 32,
    parameter int WB_BYPASS           = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_stall_ctrl_if.slave   pipe,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    typedef struct packed {
        logic                           valid;
        logic [REG_INDEX_BIT_WIDTH-1:0] dst;
        logic                           wrt_en;
    } sb_entry_t;

    localparam bit CONSIDER_WB = (WB_BYPASS == 0);

    sb_entry_t exe_q;
    sb_entry_t mem_q;
    sb_entry_t wb_q;

    logic hit_src1;
    logic hit_src2;
    logic hazard;
    logic flush;
    logic stall;

    function automatic logic entry_match(input sb_entry_t e,
                                         input logic [REG_INDEX_BIT_WIDTH-1:0] src);
        return e.valid & e.wrt_en & (e.dst == src);
    endfunction

    // The DEC instruction is compared only against older entries, never itself.
    always_comb begin
        hit_src1 = entry_match(exe_q, pipe.dec_src1) | entry_match(mem_q, pipe.dec_src1)
                 | (CONSIDER_WB & entry_match(wb_q, pipe.dec_src1));
        hit_src2 = entry_match(exe_q, pipe.dec_src2) | entry_match(mem_q, pipe.dec_src2)
                 | (CONSIDER_WB & entry_match(wb_q, pipe.dec_src2));
        hazard   = (pipe.dec_use_src1 & hit_src1) | (pipe.dec_use_src2 & hit_src2);
        flush    = pipe.exe_br_taken & exe_q.valid;
        stall    = pipe.dec_valid & hazard & ~flush;
    end

    always_comb begin
        pipe.fe_dec_en      = ~stall;
        pipe.fe_dec_flush   = flush;
        pipe.dec_exe_bubble = stall | flush | ~pipe.dec_valid;
    end

    // The shadow pipeline always advances; a bubble enters EXE whenever DEC is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= exe_q;
            if (pipe.dec_exe_bubble) begin
                exe_q <= '0;
            end else begin
                exe_q <= '{valid: 1'b1, dst: pipe.dec_dst, wrt_en: pipe.dec_reg_file_wrt_en};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench: dut_a has WB bypass and 4-bit counters, dut_b stalls
// on WB producers with 32-bit counters. Each vector targets one DUT; the other idles.
module tb_hazard_stall_ctrl;

    typedef struct {
        int          id;
        bit          sel;
        logic        rst;
        logic        dv;
        logic        u1;
        logic [3:0]  s1;
        logic        u2;
        logic [3:0]  s2;
        logic [3:0]  dst;
        logic        we;
        logic        br;
        logic        exp_en;
        logic        exp_fl;
        logic        exp_bub;
        logic [31:0] exp_sc;
        logic [31:0] exp_fc;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [3:0]  a_stall_cnt;
    logic [3:0]  a_flush_cnt;
    logic [31:0] b_stall_cnt;
    logic [31:0] b_flush_cnt;

    vec_t stim_q[$];
    vec_t exp_q[$];
    int   vectors_applied = 0;
    int   miscompares     = 0;
    int   next_id         = 0;

    hazard_stall_ctrl_if #(.REG_INDEX_BIT_WIDTH(4)) a_if ();
    hazard_stall_ctrl_if #(.REG_INDEX_BIT_WIDTH(4)) b_if ();

    hazard_stall_ctrl #(.REG_INDEX_BIT_WIDTH(4), .CNT_WIDTH(4), .WB_BYPASS(1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .pipe      (a_if.slave),
        .stall_cnt (a_stall_cnt),
        .flush_cnt (a_flush_cnt)
    );

    hazard_stall_ctrl #(.REG_INDEX_BIT_WIDTH(4), .CNT_WIDTH(32), .WB_BYPASS(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .pipe      (b_if.slave),
        .stall_cnt (b_stall_cnt),
        .flush_cnt (b_flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input bit sel, input logic rst, input logic dv,
                          input logic u1, input logic [3:0] s1,
                          input logic u2, input logic [3:0] s2,
                          input logic [3:0] dst, input logic we, input logic br,
                          input logic en, input logic fl, input logic bub,
                          input int sc, input int fc);
        vec_t v;
        v.id = next_id; v.sel = sel; v.rst = rst; v.dv = dv;
        v.u1 = u1; v.s1 = s1; v.u2 = u2; v.s2 = s2; v.dst = dst; v.we = we; v.br = br;
        v.exp_en = en; v.exp_fl = fl; v.exp_bub = bub;
        v.exp_sc = 32'(sc); v.exp_fc = 32'(fc);
        next_id++;
        stim_q.push_back(v);
    endtask

    // Inputs change 1 time unit after the rising edge; the monitor samples on the falling edge.
    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        reset = v.rst;
        a_if.dec_valid = 1'b0; a_if.exe_br_taken = 1'b0;
        a_if.dec_use_src1 = 1'b0; a_if.dec_use_src2 = 1'b0; a_if.dec_reg_file_wrt_en = 1'b0;
        b_if.dec_valid = 1'b0; b_if.exe_br_taken = 1'b0;
        b_if.dec_use_src1 = 1'b0; b_if.dec_use_src2 = 1'b0; b_if.dec_reg_file_wrt_en = 1'b0;
        if (v.sel == 1'b0) begin
            a_if.dec_valid = v.dv; a_if.dec_use_src1 = v.u1; a_if.dec_src1 = v.s1;
            a_if.dec_use_src2 = v.u2; a_if.dec_src2 = v.s2; a_if.dec_dst = v.dst;
            a_if.dec_reg_file_wrt_en = v.we; a_if.exe_br_taken = v.br;
        end else begin
            b_if.dec_valid = v.dv; b_if.dec_use_src1 = v.u1; b_if.dec_src1 = v.s1;
            b_if.dec_use_src2 = v.u2; b_if.dec_src2 = v.s2; b_if.dec_dst = v.dst;
            b_if.dec_reg_file_wrt_en = v.we; b_if.exe_br_taken = v.br;
        end
        exp_q.push_back(v);
    endtask

    task automatic checkOutput(input vec_t e);
        logic        got_en, got_fl, got_bub;
        logic [31:0] got_sc, got_fc;
        got_en  = e.sel ? b_if.fe_dec_en      : a_if.fe_dec_en;
        got_fl  = e.sel ? b_if.fe_dec_flush   : a_if.fe_dec_flush;
        got_bub = e.sel ? b_if.dec_exe_bubble : a_if.dec_exe_bubble;
        got_sc  = e.sel ? b_stall_cnt : 32'(a_stall_cnt);
        got_fc  = e.sel ? b_flush_cnt : 32'(a_flush_cnt);
        vectors_applied++;
        if (got_en !== e.exp_en) begin
            miscompares++;
            $display("[TB] FAIL v%0d dut_%s fe_dec_en got %b want %b", e.id, e.sel ? "b" : "a", got_en, e.exp_en);
        end
        if (got_fl !== e.exp_fl) begin
            miscompares++;
            $display("[TB] FAIL v%0d dut_%s fe_dec_flush got %b want %b", e.id, e.sel ? "b" : "a", got_fl, e.exp_fl);
        end
        if (got_bub !== e.exp_bub) begin
            miscompares++;
            $display("[TB] FAIL v%0d dut_%s dec_exe_bubble got %b want %b", e.id, e.sel ? "b" : "a", got_bub, e.exp_bub);
        end
        if (got_sc !== e.exp_sc) begin
            miscompares++;
            $display("[TB] FAIL v%0d dut_%s stall_cnt got %0d want %0d", e.id, e.sel ? "b" : "a", got_sc, e.exp_sc);
        end
        if (got_fc !== e.exp_fc) begin
            miscompares++;
            $display("[TB] FAIL v%0d dut_%s flush_cnt got %0d want %0d", e.id, e.sel ? "b" : "a", got_fc, e.exp_fc);
        end
    endtask

    initial begin
        vec_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired, pending=%0d", exp_q.size());
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        int sc;
        bit st;
        reset = 1'b1;
        a_if.dec_valid = 1'b0; a_if.exe_br_taken = 1'b0; a_if.dec_use_src1 = 1'b0;
        a_if.dec_use_src2 = 1'b0; a_if.dec_src1 = '0; a_if.dec_src2 = '0;
        a_if.dec_dst = '0; a_if.dec_reg_file_wrt_en = 1'b0;
        b_if.dec_valid = 1'b0; b_if.exe_br_taken = 1'b0; b_if.dec_use_src1 = 1'b0;
        b_if.dec_use_src2 = 1'b0; b_if.dec_src1 = '0; b_if.dec_src2 = '0;
        b_if.dec_dst = '0; b_if.dec_reg_file_wrt_en = 1'b0;

        //     sel rst dv u1 s1 u2 s2 dst we br   en fl bub sc fc
        addVec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1,  0, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 1,  0, 0);
        addVec(0, 0, 1, 0, 0, 0, 0, 3, 1, 0,   1, 0, 0,  0, 0);
        addVec(0, 0, 1, 1, 3, 0, 0, 5, 1, 0,   0, 0, 1,  0, 0);
        addVec(0, 0, 1, 1, 3, 0, 0, 5, 1, 0,   0, 0, 1,  1, 0);
        addVec(0, 0, 1, 1, 3, 0, 0, 5, 1, 0,   1, 0, 0,  2, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1,  2, 0);
        addVec(0, 0, 1, 0, 0, 0, 0, 3, 0, 0,   1, 0, 0,  2, 0);
        addVec(0, 0, 1, 1, 3, 0, 0, 6, 1, 0,   1, 0, 0,  2, 0);
        addVec(0, 0, 1, 0, 0, 1, 3, 8, 0, 0,   1, 0, 0,  2, 0);
        addVec(0, 0, 1, 0, 0, 1, 6, 9, 1, 0,   0, 0, 1,  2, 0);
        addVec(0, 0, 1, 0, 0, 1, 6, 9, 1, 0,   1, 0, 0,  3, 0);
        addVec(0, 0, 1, 1, 9, 0, 0, 2, 1, 1,   1, 1, 1,  3, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1,  3, 1);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 1,  3, 1);
        addVec(0, 0, 1, 1, 4, 0, 0, 4, 1, 0,   1, 0, 0,  3, 1);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1,  3, 1);

        addVec(1, 0, 1, 0, 0, 0, 0, 3, 1, 0,   1, 0, 0,  0, 0);
        addVec(1, 0, 1, 1, 3, 0, 0, 5, 1, 0,   0, 0, 1,  0, 0);
        addVec(1, 0, 1, 1, 3, 0, 0, 5, 1, 0,   0, 0, 1,  1, 0);
        addVec(1, 0, 1, 1, 3, 0, 0, 5, 1, 0,   0, 0, 1,  2, 0);
        addVec(1, 0, 1, 1, 3, 0, 0, 5, 1, 0,   1, 0, 0,  3, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1,  3, 0);
        addVec(1, 0, 1, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0,  3, 0);
        addVec(1, 0, 1, 1, 0, 1, 5, 2, 0, 0,   0, 0, 1,  3, 0);
        addVec(1, 0, 1, 1, 0, 1, 5, 2, 0, 0,   0, 0, 1,  4, 0);
        addVec(1, 0, 1, 1, 0, 1, 5, 2, 0, 0,   0, 0, 1,  5, 0);
        addVec(1, 0, 1, 1, 0, 1, 5, 2, 0, 0,   1, 0, 0,  6, 0);
        addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1,  6, 0);

        // r3 <= r3 op ... held in DEC: issue, stall, stall, repeating; counter saturates at 15.
        sc = 3;
        for (int j = 0; j < 32; j++) begin
            st = ((j % 3) != 0);
            addVec(0, 0, 1, 1, 3, 0, 0, 3, 1, 0,   !st, 0, st, sc, 1);
            if (st && sc < 15) sc++;
        end
        addVec(0, 1, 1, 1, 3, 0, 0, 3, 1, 0,   1, 0, 0,  0, 0);
        addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1,  0, 0);

        while (stim_q.size() > 0) begin
            applyStimulus(stim_q.pop_front());
        end

        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain timeout pending=%0d want 0", exp_q.size());
        end
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
